// File: rtl/rgmii_pkg.sv
// rgmii_pkg: shared constants and framer state encoding for the RGMII transmit path.
// The FCS state exists only when RGMII_TX_FCS_EN is defined.
package rgmii_pkg;

    localparam logic [7:0]  PREAMBLE    = 8'h55;
    localparam logic [7:0]  SFD         = 8'hD5;
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
`ifdef RGMII_TX_FCS_EN
        ST_FCS,
`endif
        ST_ABORT,
        ST_GAP
    } state_t;

endpackage

// File: rtl/rgmii_tx_framer_if.sv
// rgmii_tx_framer_if: payload byte stream with valid/ready/last handshake and per-byte error flag.
interface rgmii_tx_framer_if;

    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       s_last;
    logic       s_err;

    modport master (output s_data, s_valid, s_last, s_err, input s_ready);
    modport slave  (input s_data, s_valid, s_last, s_err, output s_ready);

endinterface

// File: rtl/rgmii_tx_framer_crc.sv
// crc32_d8: reflected Ethernet CRC-32, one byte per cycle, with synchronous clear and enable.
module crc32_d8
    import rgmii_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  d,
    output logic [31:0] crc
);

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            crc <= CRC_INIT;
        else if (clr)
            crc <= CRC_INIT;
        else if (en)
            crc <= crc_next(crc, d);
    end

endmodule

// File: rtl/rgmii_tx_framer.sv
// rgmii_tx_framer: GMII-style transmit framer (preamble, SFD, payload, pad, FCS, inter-frame gap).
// FCS generation is present only when RGMII_TX_FCS_EN is defined.
module rgmii_tx_framer
    import rgmii_pkg::*;
#(
    parameter int MIN_FRAME = 60,
    parameter int IFG       = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    rgmii_tx_framer_if.slave src,
    output logic [7:0]       txdata,
    output logic             txdv,
    output logic             txer,
    output logic             busy
);

    state_t      state, nxt, frame_end;
    logic [7:0]  tick;
    logic [10:0] cnt, cnt_inc;
    logic        en, in_fcs;
    logic [7:0]  fcs_byte, txdata_d;
    logic        txdv_d, txer_d, busy_d;

    assign src.s_ready = (state == ST_DATA) || (state == ST_ABORT);
    assign en          = (state == ST_DATA && src.s_valid) || (state == ST_PAD);
    assign cnt_inc     = (cnt == 11'h7FF) ? cnt : cnt + 11'd1;

`ifdef RGMII_TX_FCS_EN
    logic [31:0] crc;
    logic        crc_clr;
    logic [7:0]  crc_d;

    assign crc_clr   = !(state inside {ST_DATA, ST_PAD, ST_FCS});
    assign crc_d     = (state == ST_PAD) ? 8'h00 : src.s_data;
    assign in_fcs    = (state == ST_FCS);
    assign fcs_byte  = 8'(~crc >> {tick[1:0], 3'b000});
    assign frame_end = ST_FCS;

    crc32_d8 u_crc (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (crc_clr),
        .en   (en),
        .d    (crc_d),
        .crc  (crc)
    );
`else
    assign in_fcs    = 1'b0;
    assign fcs_byte  = 8'h00;
    assign frame_end = ST_GAP;
`endif

    // Outputs are registered, so each state emits the byte seen on the pins next cycle;
    // the first 0x55 is therefore launched from IDLE/GAP as PRE is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            tick   <= 8'd0;
            cnt    <= 11'd0;
            txdata <= 8'h00;
            txdv   <= 1'b0;
            txer   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= nxt;
            tick   <= (nxt == state) ? tick + 8'd1 : 8'd0;
            cnt    <= en ? cnt_inc : 11'd0;
            txdata <= txdata_d;
            txdv   <= txdv_d;
            txer   <= txer_d;
            busy   <= busy_d;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:  nxt = src.s_valid ? ST_PRE : ST_IDLE;
            ST_PRE:   nxt = (tick == 8'd5) ? ST_SFD : ST_PRE;
            ST_SFD:   nxt = ST_DATA;
            ST_DATA:  nxt = !src.s_valid ? ST_ABORT :
                            !src.s_last  ? ST_DATA :
                            (cnt_inc < 11'(MIN_FRAME)) ? ST_PAD : frame_end;
            ST_PAD:   nxt = (cnt_inc >= 11'(MIN_FRAME)) ? frame_end : ST_PAD;
`ifdef RGMII_TX_FCS_EN
            ST_FCS:   nxt = (tick == 8'd3) ? ST_GAP : ST_FCS;
`endif
            ST_ABORT: nxt = (src.s_valid && src.s_last) ? ST_GAP : ST_ABORT;
            // The final gap cycle launches the next preamble so the pins see exactly IFG idle cycles.
            ST_GAP:   nxt = (tick != 8'(IFG)) ? ST_GAP : src.s_valid ? ST_PRE : ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        txdata_d = (state == ST_PRE || nxt == ST_PRE) ? PREAMBLE :
                   (state == ST_SFD)                  ? SFD :
                   (state == ST_DATA && src.s_valid)  ? src.s_data :
                   in_fcs                             ? fcs_byte : 8'h00;
        txdv_d   = (state == ST_PRE) || (nxt == ST_PRE) || (state == ST_SFD) ||
                   (state == ST_DATA) || (state == ST_PAD) || in_fcs;
        txer_d   = (state == ST_DATA) && (!src.s_valid || src.s_err);
        busy_d   = (nxt != ST_IDLE);
    end

endmodule
